// File: rtl/riscv_bus_pkg.sv
// rtl/riscv_bus_pkg.sv - Shared types for the fetch / load-store memory bus arbiter
package riscv_bus_pkg;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

    localparam logic [3:0] BE_WORD  = 4'hF;
    localparam int         STREAK_W = 4;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/riscv_id_fifo.sv
// rtl/riscv_id_fifo.sv - Small synchronous FIFO tracking the issuer of each in-flight transaction
module riscv_id_fifo #(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = 1,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/riscv_bus_arbiter.sv
// rtl/riscv_bus_arbiter.sv - Arbitrates fetch and load/store requests onto one in-order memory port
module riscv_bus_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int MAX_D_STREAK    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [3:0]  i_d_be,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    output logic        o_d_gnt,
    output logic        o_d_rvalid,
    output logic [31:0] o_d_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic [3:0]  o_outstanding,
    output logic        o_resp_err
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic                if_active;
    logic                d_active;
    logic                lock_q;
    req_id_e             lock_id_q;
    logic [STREAK_W-1:0] streak_q;
    logic                resp_err_q;
    req_id_e             sel;
    bus_req_t            sel_req;
    logic                mem_req;
    logic                mem_fire;
    logic                if_grant;
    logic                d_grant;
    logic                pop;
    logic [0:0]          fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    // Requests are masked while reset clears the FIFO so nothing leaks onto the bus.
    assign if_active = i_if_req & rst_n;
    assign d_active  = i_d_req & rst_n;

    always_comb begin
        sel = REQ_D;
        if (lock_q && ((lock_id_q == REQ_IF && if_active) || (lock_id_q == REQ_D && d_active)))
            sel = lock_id_q;
        else if (if_active && !d_active)
            sel = REQ_IF;
        else if (d_active && !if_active)
            sel = REQ_D;
        else if (streak_q == STREAK_W'(MAX_D_STREAK))
            sel = REQ_IF;
    end

    assign mem_req  = (if_active | d_active) & ~fifo_full;
    assign mem_fire = mem_req & i_mem_gnt;
    assign if_grant = mem_fire & (sel == REQ_IF);
    assign d_grant  = mem_fire & (sel == REQ_D);

    always_comb begin
        sel_req = '0;
        if (mem_req) begin
            if (sel == REQ_IF) begin
                sel_req.be   = BE_WORD;
                sel_req.addr = i_if_addr;
            end else begin
                sel_req.we    = i_d_we;
                sel_req.be    = i_d_be;
                sel_req.addr  = i_d_addr;
                sel_req.wdata = i_d_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q     <= 1'b0;
            lock_id_q  <= REQ_IF;
            streak_q   <= '0;
            resp_err_q <= 1'b0;
        end else begin
            lock_q    <= mem_req & ~i_mem_gnt;
            lock_id_q <= sel;
            if (!i_if_req || if_grant)
                streak_q <= '0;
            else if (d_grant && streak_q != STREAK_W'(MAX_D_STREAK))
                streak_q <= streak_q + 1'b1;
            if (i_mem_rvalid && fifo_empty)
                resp_err_q <= 1'b1;
        end
    end

    assign pop = i_mem_rvalid & rst_n & ~fifo_empty;

    riscv_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (mem_fire),
        .push_data (sel),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign o_if_gnt      = if_grant;
    assign o_d_gnt       = d_grant;
    assign o_mem_req     = mem_req;
    assign o_mem_we      = sel_req.we;
    assign o_mem_be      = sel_req.be;
    assign o_mem_addr    = sel_req.addr;
    assign o_mem_wdata   = sel_req.wdata;
    assign o_if_rvalid   = pop & (fifo_head == REQ_IF);
    assign o_d_rvalid    = pop & (fifo_head == REQ_D);
    assign o_if_rdata    = i_mem_rdata;
    assign o_d_rdata     = i_mem_rdata;
    assign o_outstanding = 4'(fifo_count);
    assign o_resp_err    = resp_err_q;

endmodule

// File: tb/tb_riscv_bus_arbiter.sv
// tb/tb_riscv_bus_arbiter.sv - Self-checking bench for riscv_bus_arbiter
module tb_riscv_bus_arbiter;

    localparam int MAX_OUT = 2;
    localparam int MAX_D   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        if_req, d_req, d_we, mem_gnt, mem_rvalid;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic        o_if_gnt, o_if_rvalid, o_d_gnt, o_d_rvalid;
    logic        o_mem_req, o_mem_we, o_resp_err;
    logic [31:0] o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be, o_outstanding;

    riscv_bus_arbiter #(.MAX_OUTSTANDING(MAX_OUT), .MAX_D_STREAK(MAX_D)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(o_if_gnt),
        .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_be(d_be), .i_d_addr(d_addr),
        .i_d_wdata(d_wdata), .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
        .o_outstanding(o_outstanding), .o_resp_err(o_resp_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: in-order queue of issuer IDs (0 fetch, 1 data) plus arbitration memory.
    int q[$];
    bit m_lock, m_err, m_if_gnt, m_d_gnt;
    int m_owner, m_streak;

    typedef struct packed {
        logic       if_req, d_req, gnt, rv;
        logic       e_if_gnt, e_d_gnt, e_if_rv, e_d_rv;
        logic [3:0] e_out;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_lock = 0; m_err = 0; m_if_gnt = 0; m_d_gnt = 0;
        m_owner = 0; m_streak = 0;
    endtask

    // Called right after inputs change at a negedge; compares and advances the model, ends at next negedge.
    task automatic do_cycle();
        int sel;
        bit req, g, ig, dg, pop, irv, drv;
        #1;
        if (m_lock && ((m_owner == 0 && if_req) || (m_owner == 1 && d_req))) sel = m_owner;
        else if (if_req && !d_req) sel = 0;
        else if (d_req && !if_req) sel = 1;
        else sel = (m_streak == MAX_D) ? 0 : 1;
        req = (if_req || d_req) && (q.size() < MAX_OUT);
        g   = req && mem_gnt;
        ig  = g && sel == 0;
        dg  = g && sel == 1;
        pop = mem_rvalid && q.size() > 0;
        irv = 0; drv = 0;
        if (pop) begin
            irv = (q[0] == 0);
            drv = (q[0] == 1);
        end
        chk("mdl_mem_req", o_mem_req, req);
        chk("mdl_if_gnt", o_if_gnt, ig);
        chk("mdl_d_gnt", o_d_gnt, dg);
        chk("mdl_if_rvalid", o_if_rvalid, irv);
        chk("mdl_d_rvalid", o_d_rvalid, drv);
        chk("mdl_outstanding", o_outstanding, q.size());
        chk("mdl_resp_err", o_resp_err, m_err);
        if (req) begin
            chk("mdl_mem_addr", o_mem_addr, sel == 0 ? if_addr : d_addr);
            chk("mdl_mem_we", o_mem_we, sel == 0 ? 1'b0 : d_we);
            chk("mdl_mem_be", o_mem_be, sel == 0 ? 4'hF : d_be);
            chk("mdl_mem_wdata", o_mem_wdata, sel == 0 ? 32'h0 : d_wdata);
        end
        if (irv) chk("mdl_if_rdata", o_if_rdata, mem_rdata);
        if (drv) chk("mdl_d_rdata", o_d_rdata, mem_rdata);
        if (mem_rvalid && q.size() == 0) m_err = 1;
        if (pop) void'(q.pop_front());
        if (g) q.push_back(sel);
        m_lock  = req && !mem_gnt;
        m_owner = sel;
        if (!if_req || ig) m_streak = 0;
        else if (dg && m_streak < MAX_D) m_streak++;
        m_if_gnt = ig;
        m_d_gnt  = dg;
        @(negedge clk);
    endtask

    task automatic idle();
        if_req = 0; d_req = 0; d_we = 0; d_be = 4'h0; mem_gnt = 0; mem_rvalid = 0;
    endtask

    initial begin
        int exp_o[6];
        logic [5:0] exp_req;
        if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        idle();
        model_clear();

        // Reset: requests and a stray response are all ignored.
        #1 rst_n = 0;
        if_req = 1; d_req = 1; mem_gnt = 1; mem_rvalid = 1;
        @(negedge clk); #1;
        chk("rst_mem_req", o_mem_req, 0);
        chk("rst_if_gnt", o_if_gnt, 0);
        chk("rst_d_gnt", o_d_gnt, 0);
        chk("rst_rvalid", {o_if_rvalid, o_d_rvalid}, 0);
        chk("rst_outstanding", o_outstanding, 0);
        chk("rst_resp_err", o_resp_err, 0);
        @(negedge clk);
        idle();
        rst_n = 1;

        // Both requesting, gnt=1, latency 1: grant order D,D,D,D,IF,D,D,D,D,IF.
        vecs[0] = 12'b1110_0100_0000;
        for (int i = 1; i <= 3; i++) vecs[i] = 12'b1111_0101_0001;
        vecs[4] = 12'b1111_1001_0001;
        vecs[5] = 12'b1111_0110_0001;
        for (int i = 6; i <= 8; i++) vecs[i] = 12'b1111_0101_0001;
        vecs[9]  = 12'b1111_1001_0001;
        vecs[10] = 12'b0001_0010_0001;
        for (int i = 0; i < 11; i++) begin
            vec_t v;
            v = vecs[i];
            if_req = v.if_req; d_req = v.d_req; mem_gnt = v.gnt; mem_rvalid = v.rv;
            if_addr = 32'h1000 + 4 * i; d_addr = 32'h2000 + 4 * i; d_wdata = $urandom;
            d_we = 0; d_be = 4'hF; mem_rdata = $urandom;
            #1;
            chk("tbl_if_gnt", o_if_gnt, v.e_if_gnt);
            chk("tbl_d_gnt", o_d_gnt, v.e_d_gnt);
            chk("tbl_if_rvalid", o_if_rvalid, v.e_if_rv);
            chk("tbl_d_rvalid", o_d_rvalid, v.e_d_rv);
            chk("tbl_outstanding", o_outstanding, v.e_out);
            do_cycle();
        end

        // Fetch only, addresses 0x100..0x10C, latency 1.
        for (int k = 0; k < 5; k++) begin
            idle();
            if_req = (k < 4); if_addr = 32'h100 + 4 * k; mem_gnt = 1;
            mem_rvalid = (k > 0); mem_rdata = 32'hA000 + k;
            #1;
            chk("fetch_gnt", o_if_gnt, k < 4);
            chk("fetch_rvalid", o_if_rvalid, k > 0);
            chk("fetch_outstanding_le1", o_outstanding <= 1, 1);
            if (k < 4) chk("fetch_addr", o_mem_addr, 32'h100 + 4 * k);
            do_cycle();
        end

        // Data write stalled three cycles while fetch waits: bus stays locked on it.
        for (int c = 0; c < 4; c++) begin
            idle();
            if_req = 1; if_addr = 32'h300;
            d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
            mem_gnt = (c == 3);
            #1;
            chk("lock_addr", o_mem_addr, 32'h200);
            chk("lock_be", o_mem_be, 4'b0011);
            chk("lock_wdata", o_mem_wdata, 32'hDEADBEEF);
            chk("lock_we", o_mem_we, 1);
            chk("lock_if_gnt", o_if_gnt, 0);
            chk("lock_d_gnt", o_d_gnt, c == 3);
            do_cycle();
        end
        idle(); mem_rvalid = 1; mem_rdata = 32'h0;
        #1 chk("lock_wr_ack", o_d_rvalid, 1);
        do_cycle();

        // Responses withheld until the FIFO fills, then one response frees one slot.
        exp_req = 6'b010011;
        exp_o   = '{0, 1, 2, 2, 1, 2};
        for (int c = 0; c < 6; c++) begin
            idle();
            if_req = 1; if_addr = 32'h400 + 4 * c; mem_gnt = 1; mem_rvalid = (c == 3);
            #1;
            chk("full_mem_req", o_mem_req, exp_req[c]);
            chk("full_outstanding", o_outstanding, exp_o[c]);
            do_cycle();
        end
        for (int c = 0; c < 2; c++) begin
            idle(); mem_rvalid = 1;
            do_cycle();
        end

        // Interleaved fetch then data read: responses routed back in order.
        idle(); if_req = 1; if_addr = 32'h0; mem_gnt = 1;
        do_cycle();
        idle(); d_req = 1; d_addr = 32'h40; mem_gnt = 1;
        do_cycle();
        idle(); mem_rvalid = 1; mem_rdata = 32'h11111111;
        #1;
        chk("ilv_if_rvalid", o_if_rvalid, 1);
        chk("ilv_if_rdata", o_if_rdata, 32'h11111111);
        chk("ilv_d_rvalid0", o_d_rvalid, 0);
        do_cycle();
        idle(); mem_rvalid = 1; mem_rdata = 32'h22222222;
        #1;
        chk("ilv_d_rvalid", o_d_rvalid, 1);
        chk("ilv_d_rdata", o_d_rdata, 32'h22222222);
        chk("ilv_if_rvalid0", o_if_rvalid, 0);
        do_cycle();

        // Response with nothing in flight.
        idle(); mem_rvalid = 1;
        #1 chk("err_no_rvalid", {o_if_rvalid, o_d_rvalid}, 0);
        do_cycle();
        for (int c = 0; c < 3; c++) begin
            idle(); if_req = (c > 0); if_addr = 32'h500 + 4 * c; mem_gnt = 1;
            #1 chk("err_sticky", o_resp_err, 1);
            do_cycle();
        end

        // Reset with two transactions in flight.
        idle(); if_req = 1;
        #2 rst_n = 0;
        #1;
        chk("midrst_outstanding", o_outstanding, 0);
        chk("midrst_resp_err", o_resp_err, 0);
        chk("midrst_mem_req", o_mem_req, 0);
        model_clear();
        @(negedge clk);
        idle();
        rst_n = 1;

        // Randomized traffic; a requester holds its fields until granted.
        for (int i = 0; i < 400; i++) begin
            if (!(if_req && !m_if_gnt)) begin
                if_req  = ($urandom % 4) != 0;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!(d_req && !m_d_gnt)) begin
                d_req   = 1'($urandom);
                d_we    = 1'($urandom);
                d_be    = 4'($urandom);
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            mem_gnt    = ($urandom % 4) != 0;
            mem_rvalid = (q.size() > 0) && ($urandom % 3 == 0);
            mem_rdata  = $urandom;
            do_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_bus_arbiter.md
Name: riscv_bus_arbiter

Overview:
- Shares the single memory bus port between the instruction-fetch requester (read-only) and the load/store unit requester (read/write, byte enables).
- Sits between the fetch stage, the riscv_mem stage and the memory model. Drives the stall that riscv_mem reports as o_bus_stall.
- Responses return strictly in order. A small ID FIFO routes each response back to the requester that issued it.

Parameters:
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered transactions (1..8).
- MAX_D_STREAK, 4: consecutive data grants allowed while fetch waits before fetch is forced through (1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_if_req  in  1  fetch request
- i_if_addr  in  32  fetch word address
- o_if_gnt  out  1  fetch request accepted this cycle
- o_if_rvalid  out  1  fetch read data valid
- o_if_rdata  out  32  fetch read data
- i_d_req  in  1  data request
- i_d_we  in  1  data write (1) / read (0)
- i_d_be  in  4  data byte enables
- i_d_addr  in  32  data address
- i_d_wdata  in  32  data write data
- o_d_gnt  out  1  data request accepted this cycle
- o_d_rvalid  out  1  data response valid (read data or write ack)
- o_d_rdata  out  32  data read data
- o_mem_req  out  1  request to memory
- o_mem_we  out  1  write to memory
- o_mem_be  out  4  byte enables to memory (4'hF for fetch)
- o_mem_addr  out  32  address to memory
- o_mem_wdata  out  32  write data to memory (0 for fetch)
- i_mem_gnt  in  1  memory accepts request this cycle
- i_mem_rvalid  in  1  memory response valid (every accepted request, writes included)
- i_mem_rdata  in  32  memory read data
- o_outstanding  out  4  transactions in flight
- o_resp_err  out  1  sticky: response arrived with no transaction in flight

Behaviour:
- Reset (async, rst_n=0):
  - lock, streak counter and ID FIFO are cleared; o_resp_err=0; o_outstanding=0.
  - All combinational outputs are 0 because both requests are ignored while the FIFO is being cleared.
- Request/grant:
  - o_mem_req = (i_if_req | i_d_req) & !fifo_full.
  - o_mem_* fields are muxed from the selected requester.
  - Grant to the selected requester = o_mem_req & i_mem_gnt, in the same cycle (zero latency).
  - Requesters hold address/data stable until granted.
- Selection, evaluated in priority order:
  - (1) Lock: if last cycle o_mem_req=1 and i_mem_gnt=0, the previous selection is kept while that requester still requests. This keeps the bus stable.
  - (2) Otherwise, if only one requester is active, it is selected.
  - (3) If both are active: data is selected unless streak == MAX_D_STREAK, in which case fetch is selected.
- Streak counter:
  - +1 on each data grant while i_if_req=1.
  - Cleared on a fetch grant, or in any cycle with i_if_req=0.
  - Saturates at MAX_D_STREAK.
- In-flight tracking:
  - Each grant pushes a 1-bit ID (0=fetch, 1=data) into the ID FIFO of depth MAX_OUTSTANDING.
  - i_mem_rvalid pops the head and asserts o_if_rvalid or o_d_rvalid in the same cycle.
  - i_mem_rdata drives both rdata outputs unconditionally; only rvalid qualifies it.
- FIFO full: o_mem_req=0 and no grant, even if a pop occurs in the same cycle. This is conservative and deterministic; a push is never simultaneous with full.
- Push and pop in the same cycle (not full): count is unchanged; order is preserved.
- i_mem_rvalid with an empty FIFO: no rvalid to either requester; o_resp_err is set and held until reset.
- o_outstanding is the FIFO count, registered.
- Reset mid-operation: in-flight IDs are discarded. The memory must also be reset; late responses flag o_resp_err.
- Stall exported to the pipeline = req & !gnt per requester; the stall signal itself is produced outside this block.

Decomposition:
- Shared package riscv_bus_pkg:
  - requester ID enum (REQ_IF=0, REQ_D=1)
  - BE_WORD=4'hF
  - bus request struct {we, be, addr, wdata}
- Sub-module riscv_id_fifo: parameterised depth/width synchronous FIFO with push, pop, full, empty and count, async active-low reset.

Test Plan:
- Fetch only, i_mem_gnt=1, memory latency 1, addr 0x100..0x10C -> o_if_gnt each cycle; four o_if_rvalid in order; o_outstanding stays ≤1.
- Both requesting continuously, MAX_D_STREAK=4, gnt always 1 -> grant order D,D,D,D,IF,D,D,D,D,IF.
- Data write be=4'b0011 addr 0x200 wdata 0xDEADBEEF, i_mem_gnt low for 3 cycles while fetch also requests -> bus fields held stable (lock); o_d_gnt on the 4th cycle; o_if_gnt not asserted meanwhile.
- MAX_OUTSTANDING=2, gnt=1, responses withheld -> two grants, then o_mem_req=0. A response in cycle N gives o_mem_req=1 in cycle N+1; o_outstanding shows 2→1→2.
- Interleaved IF read 0x0, then D read 0x40, rdata 0x11111111 and 0x22222222 -> o_if_rvalid with 0x11111111, then o_d_rvalid with 0x22222222.
- i_mem_rvalid with nothing outstanding -> no rvalid out; o_resp_err=1 until rst_n pulse. Assert rst_n=0 with 2 in flight -> o_outstanding=0 immediately.
